// File: rtl/multiword_add_sub.sv
// Multiword add/subtract engine built on a blocked carry-lookahead adder.
// Operands stream in one word per transfer, least-significant word first,
// with in_last marking the final word. Each accepted word produces one
// registered result word one cycle later; the carry chains between words
// through a register. Flags CF/OF/ZF are presented only on the final word.
//
// Ports (multiword_add_sub):
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input handshake; A, B, SUB, in_last ride with it
//   out_valid/out_ready   output handshake; S, out_last, CF, OF, ZF ride with it
//
// Ports (carry_lookahead_adder):
//   A, B, Cin -> S, Cout, OF (signed overflow of the MSB)

module carry_lookahead_adder #(
  parameter int DATA_WIDTH = 16,
  parameter int BLOCK_SIZE = 4
) (
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  Cin,
  output logic [DATA_WIDTH-1:0] S,
  output logic                  Cout,
  output logic                  OF
);
  localparam int NUM_BLOCKS = DATA_WIDTH / BLOCK_SIZE;

  logic [DATA_WIDTH-1:0] g;
  logic [DATA_WIDTH-1:0] p;
  logic [DATA_WIDTH:0]   c;

  assign g = A & B;
  assign p = A ^ B;

  // Carries inside a block are flattened sum-of-products terms of the
  // block's carry-in; blocks ripple into each other.
  always_comb begin
    logic acc;
    logic pp;
    c    = '0;
    c[0] = Cin;
    for (int blk = 0; blk < NUM_BLOCKS; blk++) begin
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        acc = g[blk*BLOCK_SIZE + i];
        pp  = p[blk*BLOCK_SIZE + i];
        for (int j = i - 1; j >= 0; j--) begin
          acc = acc | (pp & g[blk*BLOCK_SIZE + j]);
          pp  = pp & p[blk*BLOCK_SIZE + j];
        end
        c[blk*BLOCK_SIZE + i + 1] = acc | (pp & c[blk*BLOCK_SIZE]);
      end
    end
  end

  assign S    = p ^ c[DATA_WIDTH-1:0];
  assign Cout = c[DATA_WIDTH];
  assign OF   = c[DATA_WIDTH] ^ c[DATA_WIDTH-1];
endmodule

// State table
//   state | meaning
//   FIRST | next accepted word starts a new operation
//   CONT  | operation in progress, carry and SUB come from registers
module multiword_add_sub #(
  parameter int DATA_WIDTH = 16,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  SUB,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] S,
  output logic                  out_last,
  output logic                  CF,
  output logic                  OF,
  output logic                  ZF
);
  typedef enum logic {FIRST, CONT} state_e;

  state_e                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] s_q, s_d;
  logic                  last_q, last_d;
  logic                  carry_q, carry_d;
  logic                  of_q, of_d;
  logic                  zrun_q, zrun_d;
  logic                  sub_q, sub_d;

  logic                  first_w;
  logic                  sub_eff;
  logic                  cin;
  logic [DATA_WIDTH-1:0] b_x;
  logic [DATA_WIDTH-1:0] sum;
  logic                  cout;
  logic                  add_of;
  logic                  in_xfer;
  logic                  out_xfer;

  assign first_w  = (state_q == FIRST);
  assign sub_eff  = first_w ? SUB : sub_q;
  assign cin      = first_w ? sub_eff : carry_q;
  assign b_x      = B ^ {DATA_WIDTH{sub_eff}};

  assign in_ready = !valid_q || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = valid_q && out_ready;

  carry_lookahead_adder #(
    .DATA_WIDTH (DATA_WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_cla (
    .A    (A),
    .B    (b_x),
    .Cin  (cin),
    .S    (sum),
    .Cout (cout),
    .OF   (add_of)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    s_d     = s_q;
    last_d  = last_q;
    carry_d = carry_q;
    of_d    = of_q;
    zrun_d  = zrun_q;
    sub_d   = sub_q;
    if (in_xfer) begin
      state_d = in_last ? FIRST : CONT;
      valid_d = 1'b1;
      s_d     = sum;
      last_d  = in_last;
      carry_d = cout;
      of_d    = add_of;
      // running zero restarts at the first word of each operation
      zrun_d  = (first_w || zrun_q) && (sum == '0);
      sub_d   = sub_eff;
    end else if (out_xfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FIRST;
      valid_q <= 1'b0;
      s_q     <= '0;
      last_q  <= 1'b0;
      carry_q <= 1'b0;
      of_q    <= 1'b0;
      zrun_q  <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      s_q     <= s_d;
      last_q  <= last_d;
      carry_q <= carry_d;
      of_q    <= of_d;
      zrun_q  <= zrun_d;
      sub_q   <= sub_d;
    end
  end

  assign out_valid = valid_q;
  assign S         = s_q;
  assign out_last  = last_q;
  assign CF        = valid_q && last_q && carry_q;
  assign OF        = valid_q && last_q && of_q;
  assign ZF        = valid_q && last_q && zrun_q;
endmodule

// File: tb/tb_multiword_add_sub.sv
module tb_multiword_add_sub;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        SUB;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] S;
  logic        out_last;
  logic        CF;
  logic        OF;
  logic        ZF;

  typedef struct packed {
    logic [15:0] s;
    logic        last;
    logic        cf;
    logic        of;
    logic        zf;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic m_first = 1'b1;
  logic m_sub   = 1'b0;
  logic m_carry = 1'b0;
  logic m_zero  = 1'b0;

  always #5 clk = ~clk;

  multiword_add_sub #(.DATA_WIDTH(16), .BLOCK_SIZE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .SUB       (SUB),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .out_last  (out_last),
    .CF        (CF),
    .OF        (OF),
    .ZF        (ZF)
  );

  // Reference multi-precision model: 17-bit arithmetic per word.
  task automatic model_push(input logic [15:0] a, input logic [15:0] b,
                            input logic sub, input logic last);
    logic        sub_e;
    logic        c_in;
    logic [15:0] bx;
    logic [16:0] sum;
    logic        zero;
    exp_t        e;
    sub_e = m_first ? sub : m_sub;
    c_in  = m_first ? sub : m_carry;
    if (m_first) m_sub = sub;
    bx    = sub_e ? ~b : b;
    sum   = {1'b0, a} + {1'b0, bx} + {16'd0, c_in};
    zero  = (m_first || m_zero) && (sum[15:0] == 16'd0);
    e.s    = sum[15:0];
    e.last = last;
    e.cf   = last && sum[16];
    e.of   = last && (a[15] == bx[15]) && (sum[15] != a[15]);
    e.zf   = last && zero;
    m_carry = sum[16];
    m_zero  = zero;
    m_first = last;
    sb_q.push_back(e);
  endtask

  task automatic model_reset();
    m_first = 1'b1;
    m_sub   = 1'b0;
    m_carry = 1'b0;
    m_zero  = 1'b0;
  endtask

  // Scoreboard monitor: every output transfer pops one expected word.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got S=%h last=%b with no expected word", S, out_last);
      end else begin
        e = sb_q.pop_front();
        if ({S, out_last, CF, OF, ZF} !== e) begin
          n_fail++;
          $display("FAIL sb_word: got S=%h last=%b CF=%b OF=%b ZF=%b, want S=%h last=%b CF=%b OF=%b ZF=%b",
                   S, out_last, CF, OF, ZF, e.s, e.last, e.cf, e.of, e.zf);
        end
      end
    end
  end

  // Drive one word (model updated first); returns just after acceptance.
  task automatic send_word(input logic [15:0] a, input logic [15:0] b,
                           input logic sub, input logic last);
    bit acc;
    model_push(a, b, sub, last);
    A = a; B = b; SUB = sub; in_last = last; in_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b, want 1 within 100 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d words still pending, want 0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; SUB = 1'b0;
    in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, S, out_last, CF, OF, ZF} !== {1'b1, 1'b0, 16'h0000, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b vld=%b S=%h last=%b CF=%b OF=%b ZF=%b, want 1 0 0000 0 0 0 0",
               in_ready, out_valid, S, out_last, CF, OF, ZF);
    end
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    send_word(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    n_checks++;
    if ({out_valid, S, CF, OF, ZF, out_last} !== {1'b1, 16'h0000, 4'b1011}) begin
      n_fail++;
      $display("FAIL single_add: vld=%b S=%h CF=%b OF=%b ZF=%b last=%b, want 1 0000 1 0 1 1",
               out_valid, S, CF, OF, ZF, out_last);
    end
    send_word(16'h8000, 16'h0001, 1'b1, 1'b1);
    n_checks++;
    if ({S, CF, OF, ZF, out_last} !== {16'h7FFF, 4'b1101}) begin
      n_fail++;
      $display("FAIL single_sub_ovf: S=%h CF=%b OF=%b ZF=%b last=%b, want 7fff 1 1 0 1",
               S, CF, OF, ZF, out_last);
    end
    drain();
  endtask

  task automatic test_two_word_add();
    out_ready = 1'b1;
    send_word(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    n_checks++;
    if ({S, CF, OF, ZF, out_last} !== {16'h0000, 4'b0000}) begin
      n_fail++;
      $display("FAIL add2_w0: S=%h CF=%b OF=%b ZF=%b last=%b, want 0000 0 0 0 0",
               S, CF, OF, ZF, out_last);
    end
    send_word(16'h0000, 16'h0000, 1'b0, 1'b1);
    n_checks++;
    if ({S, CF, OF, ZF, out_last} !== {16'h0001, 4'b0001}) begin
      n_fail++;
      $display("FAIL add2_w1: S=%h CF=%b OF=%b ZF=%b last=%b, want 0001 0 0 0 1",
               S, CF, OF, ZF, out_last);
    end
    drain();
  endtask

  task automatic test_two_word_sub();
    out_ready = 1'b1;
    send_word(16'h0000, 16'h0001, 1'b1, 1'b0);
    n_checks++;
    if (S !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sub2_w0: S=%h, want ffff", S);
    end
    // SUB=0 on the second word must be ignored
    send_word(16'h0000, 16'h0000, 1'b0, 1'b1);
    n_checks++;
    if ({S, CF, OF, ZF, out_last} !== {16'hFFFF, 4'b0001}) begin
      n_fail++;
      $display("FAIL sub2_w1: S=%h CF=%b OF=%b ZF=%b last=%b, want ffff 0 0 0 1",
               S, CF, OF, ZF, out_last);
    end
    drain();
  endtask

  task automatic test_backpressure();
    bit acc;
    out_ready = 1'b0;
    send_word(16'h1234, 16'h1111, 1'b0, 1'b1);
    model_push(16'h0005, 16'h0003, 1'b1, 1'b1);
    A = 16'h0005; B = 16'h0003; SUB = 1'b1; in_last = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, S} !== {1'b0, 1'b1, 16'h2345}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: rdy=%b vld=%b S=%h, want 0 1 2345", k, in_ready, out_valid, S);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
    end
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%b, want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, S} !== {1'b1, 16'h0002}) begin
      n_fail++;
      $display("FAIL bp_second: vld=%b S=%h, want 1 0002", out_valid, S);
    end
    drain();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_idle: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_op();
    out_ready = 1'b1;
    send_word(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    drain();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({in_ready, out_valid, S} !== {1'b1, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL rst_mid: rdy=%b vld=%b S=%h, want 1 0 0000", in_ready, out_valid, S);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    send_word(16'h0001, 16'h0001, 1'b0, 1'b1);
    n_checks++;
    if ({S, CF, OF, ZF, out_last} !== {16'h0002, 4'b0001}) begin
      n_fail++;
      $display("FAIL rst_fresh: S=%h CF=%b OF=%b ZF=%b last=%b, want 0002 0 0 0 1",
               S, CF, OF, ZF, out_last);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int gaps;
    int n_words;
    gaps    = 0;
    n_words = 60;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < n_words; i++) begin
          logic [15:0] a;
          logic [15:0] b;
          logic        lst;
          a   = 16'($urandom);
          b   = 16'($urandom);
          if (i % 7 == 3) begin a = 16'hFFFF; b = 16'h0001; end
          if (i % 11 == 5) begin a = 16'h0000; b = 16'h0000; end
          lst = ($urandom_range(0, 2) == 0) || (i == n_words - 1);
          send_word(a, b, 1'($urandom_range(0, 1)), lst);
        end
      end
      begin
        @(posedge clk);
        for (int k = 0; k < n_words; k++) begin
          @(negedge clk);
          if (!out_valid) gaps++;
        end
      end
    join
    n_checks++;
    if (gaps != 0) begin
      n_fail++;
      $display("FAIL stream_gaps: %0d idle output cycles, want 0", gaps);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_word_add();
    test_two_word_sub();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/multiword_add_sub.md
MULTIWORD_ADD_SUB -- requirements
Module: multiword_add_sub

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of one operand word and one result word.
REQ-002 Parameter BLOCK_SIZE, default 4: lookahead block size of the internal carry_lookahead_adder; DATA_WIDTH SHALL be a multiple of BLOCK_SIZE.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1: upstream presents a valid operand word pair.
REQ-006 Port in_ready  output  1: block accepts the word pair this cycle.
REQ-007 Port A  input  DATA_WIDTH: minuend or augend word, least-significant word first.
REQ-008 Port B  input  DATA_WIDTH: subtrahend or addend word.
REQ-009 Port SUB  input  1: 1 = A-B, 0 = A+B; sampled on the first word of an operation only.
REQ-010 Port in_last  input  1: marks the most-significant (final) word of an operation.
REQ-011 Port out_valid  output  1: result word is valid.
REQ-012 Port out_ready  input  1: downstream accepts the result word.
REQ-013 Port S  output  DATA_WIDTH: result word.
REQ-014 Port out_last  output  1: result word is the final word of its operation.
REQ-015 Port CF  output  1: carry out of the final word; qualified by out_valid and out_last, else 0.
REQ-016 Port OF  output  1: signed overflow of the final word; qualified as CF.
REQ-017 Port ZF  output  1: all result words of the operation are zero; qualified as CF.

Function
REQ-018 Input transfer SHALL occur when in_valid and in_ready are both 1; output transfer when out_valid and out_ready are both 1.
REQ-019 in_ready SHALL equal (!out_valid || out_ready); no combinational path from in_valid to in_ready.
REQ-020 The block SHALL instantiate one carry_lookahead_adder (DATA_WIDTH, BLOCK_SIZE), driving B with B XOR {DATA_WIDTH{sub_eff}}.
REQ-021 sub_eff SHALL be SUB on the first word and the registered SUB of the operation on later words.
REQ-022 Adder Cin SHALL be sub_eff on the first word and the registered carry of the previous accepted word on later words.
REQ-023 FSM states: FIRST (next accepted word starts an operation) and CONT (operation in progress).
REQ-024 FIRST -> CONT on input transfer with in_last=0; CONT -> FIRST on input transfer with in_last=1; FIRST stays FIRST on a transfer with in_last=1 (single-word operation); no transition without a transfer.
REQ-025 On each input transfer the block SHALL register S, out_last=in_last, adder carry, and set out_valid=1; latency exactly one cycle from transfer to out_valid.
REQ-026 out_valid SHALL clear after an output transfer with no simultaneous input transfer; simultaneous input and output transfers SHALL load the new word with out_valid held 1.
REQ-027 While out_valid=1 and out_ready=0, S, out_last, CF, OF, ZF SHALL hold stable.
REQ-028 CF SHALL be the raw adder carry out (for subtraction, 1 = no borrow); OF SHALL be the adder OF of the final word.
REQ-029 Running zero flag SHALL reset to 1 at the first word, AND with (S==0) per word; ZF presents the value including the final word.
REQ-030 SUB on non-first words SHALL be ignored; in_last is the sole operation delimiter; there is no word-count limit.

Reset
REQ-031 While rst_n=0: state=FIRST, out_valid=0, S=0, out_last=0, CF=0, OF=0, ZF=0, carry and stored SUB cleared; in_ready=1.
REQ-032 Reset asserted mid-operation SHALL discard the partial operation; the first word after release starts a new operation.

Verification
REQ-033 Single word, DATA_WIDTH=16: SUB=0, A=0xFFFF, B=0x0001, in_last=1 -> next cycle S=0x0000, CF=1, OF=0, ZF=1, out_last=1.
REQ-034 Two words, add: (A,B)=(0xFFFF,0x0001) then (0x0000,0x0000, last) -> S=0x0000 then S=0x0001; CF=0, ZF=0 on second.
REQ-035 Two words, SUB=1: (0x0000,0x0001) then (0x0000,0x0000, last) -> S=0xFFFF, 0xFFFF; CF=0, OF=0, ZF=0; signed overflow case 0x8000-0x0001 single word -> S=0x7FFF, OF=1.
REQ-036 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, S stable, no word lost or duplicated after out_ready=1.
REQ-037 Reset mid-operation: first word accepted, rst_n pulsed low, then single word 0x0001+0x0001 last -> S=0x0002, Cin not taken from stale carry.
REQ-038 Full-throughput stream, out_ready=1: back-to-back words every cycle, out_valid continuously 1, results match a reference multi-precision model.
